// File: rtl/s2p_if.sv
// Serial display link bundle: serializer-side pins plus the receiver's decoded outputs.
// The serializer (or a testbench) is the master; the receiver is the slave.
interface s2p_if #(
  parameter int BIT_WIDTH = 64
);
  localparam int CW = $clog2(BIT_WIDTH + 1);

  logic                 sclk;
  logic                 sclrn;
  logic                 sout;
  logic                 en;
  logic [BIT_WIDTH-1:0] par_out;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;
  logic [CW-1:0]        bit_count;

  modport master (
    output sclk, sclrn, sout, en,
    input  par_out, valid, frame_err, busy, bit_count
  );

  modport slave (
    input  sclk, sclrn, sout, en,
    output par_out, valid, frame_err, busy, bit_count
  );
endinterface

// File: rtl/s2p_receiver.sv
// Deserialises the seven-segment serial link (sclk/sclrn/sout/en) into a parallel word,
// pulsing valid on each good frame and frame_err on short, empty or overrun frames.
module s2p_receiver #(
  parameter int BIT_WIDTH   = 64,  // frame length, >= 2
  parameter int SYNC_STAGES = 2    // synchroniser depth, >= 2
) (
  input  logic clk,
  input  logic rst,
  s2p_if.slave bus
);

  localparam int            CW   = $clog2(BIT_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_WIDTH);

  // Synchroniser chains; all four share the same depth so sout stays aligned with sclk.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sclrn_sync;
  logic [SYNC_STAGES-1:0] sout_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic                   sclk_d;
  logic                   en_d;

  logic sclk_s;
  logic sclrn_s;
  logic sout_s;
  logic en_s;
  logic sclk_rise;
  logic en_rise;

  logic [BIT_WIDTH-1:0] shreg_q, shreg_n;
  logic [BIT_WIDTH-1:0] par_q,   par_n;
  logic [CW-1:0]        cnt_q,   cnt_n;
  logic                 ovr_q,   ovr_n;
  logic                 valid_q, valid_n;
  logic                 err_q,   err_n;

  // Idle levels on reset keep the edge detectors quiet when rst is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '1;
      sclrn_sync <= '1;
      sout_sync  <= '0;
      en_sync    <= '0;
      sclk_d     <= 1'b1;
      en_d       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns these into real shift chains rather than wires.
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0],  bus.sclk};
      sclrn_sync <= {sclrn_sync[SYNC_STAGES-2:0], bus.sclrn};
      sout_sync  <= {sout_sync[SYNC_STAGES-2:0],  bus.sout};
      en_sync    <= {en_sync[SYNC_STAGES-2:0],    bus.en};
      sclk_d     <= sclk_sync[SYNC_STAGES-1];
      en_d       <= en_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sclrn_s   = sclrn_sync[SYNC_STAGES-1];
  assign sout_s    = sout_sync[SYNC_STAGES-1];
  assign en_s      = en_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign en_rise   = en_s & ~en_d;

  // Frame datapath. The en evaluation looks at the post-shift count and data so that
  // a final sclk edge landing in the same synchronised cycle as en still counts.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skipped one
    // would infer a latch.
    shreg_n = shreg_q;
    par_n   = par_q;
    cnt_n   = cnt_q;
    ovr_n   = ovr_q;
    valid_n = 1'b0;
    err_n   = 1'b0;

    if (!sclrn_s) begin
      shreg_n = '0;
      cnt_n   = '0;
      ovr_n   = 1'b0;
    end else begin
      if (sclk_rise) begin
        shreg_n = {shreg_q[BIT_WIDTH-2:0], sout_s};
        if (cnt_q < FULL) begin
          cnt_n = cnt_q + CW'(1);
        end else begin
          ovr_n = 1'b1;
        end
      end

      if (en_rise) begin
        if ((cnt_n == FULL) && !ovr_n) begin
          par_n   = shreg_n;
          valid_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
        cnt_n = '0;
        ovr_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_n;
      par_q   <= par_n;
      cnt_q   <= cnt_n;
      ovr_q   <= ovr_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  assign bus.par_out   = par_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (cnt_q != '0);
  assign bus.bit_count = cnt_q;

  a_pulse_exclusive : assert property (@(posedge clk) disable iff (rst) !(valid_q && err_q));
  a_count_bounded   : assert property (@(posedge clk) disable iff (rst) cnt_q <= FULL);
  a_overrun_at_full : assert property (@(posedge clk) disable iff (rst) ovr_q |-> (cnt_q == FULL));

endmodule

// File: tb/tb_s2p_receiver.sv
// Self-checking bench for s2p_receiver: drives the serial link at a legal rate and
// compares against a bit-queue model of the frame rules.
module tb_s2p_receiver;

  localparam int BW = 64;
  localparam int SS = 2;
  localparam int PH = SS + 2;  // clk cycles per sclk phase, above the SS+1 minimum
  localparam int CW = $clog2(BW + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s2p_if #(.BIT_WIDTH(BW)) bus ();

  s2p_receiver #(.BIT_WIDTH(BW), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor, sampled on the falling edge.
  int            n_valid = 0;
  int            n_err   = 0;
  int            n_both  = 0;
  int            last_valid_cyc = -1;
  logic [BW-1:0] cap;
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      cap = bus.par_out;
    end
    if (bus.frame_err === 1'b1) n_err++;
    if (bus.valid === 1'b1 && bus.frame_err === 1'b1) n_both++;
  end

  // Reference model: the bits seen since the last clear/evaluation, and the last good word.
  bit            q[$];
  logic [BW-1:0] exp_par = '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    bus.sout = b;
    bus.sclk = 1'b0;
    tick(PH);
    bus.sclk = 1'b1;
    q.push_back(b);
    tick(PH);
  endtask

  task automatic send_word(input logic [BW-1:0] w);
    for (int i = BW - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_count(input string name);
    int exp_cnt;
    exp_cnt = (q.size() > BW) ? BW : q.size();
    checks++;
    if (bus.bit_count !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL %s bit_count: got %0d, required %0d", name, bus.bit_count, exp_cnt);
    end
    checks++;
    if (bus.busy !== (exp_cnt != 0)) begin
      errors++;
      $display("FAIL %s busy: got %b, required %b", name, bus.busy, exp_cnt != 0);
    end
  endtask

  // Hold sclrn low for 'periods' sclk periods; bit_count must read 0 midway.
  task automatic clear_pulse(input string name, input int periods);
    bus.sclrn = 1'b0;
    tick(periods * PH);
    checks++;
    if (bus.bit_count !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s clear: got bit_count=%0d busy=%b, required 0/0", name, bus.bit_count, bus.busy);
    end
    tick(periods * PH);
    bus.sclrn = 1'b1;
    q.delete();
    tick(PH);
  endtask

  // Raise en (optionally together with a final sclk rise) and check the outcome.
  // With en first sampled at edge E0, valid is seen after edge E0+SS (cycle SS+1 counting E0..E0+1 as 1).
  task automatic frame_end(input string name, input bit coincident, input bit last_b);
    int            v0, e0, c_drive;
    bit            ok;
    logic [BW-1:0] w;
    v0 = n_valid;
    e0 = n_err;
    if (coincident) begin
      bus.sout = last_b;
      bus.sclk = 1'b0;
      tick(PH);
      q.push_back(last_b);
      bus.sclk = 1'b1;
    end
    bus.en  = 1'b1;
    c_drive = cyc;
    ok = (q.size() == BW);
    w  = '0;
    if (ok) for (int i = 0; i < BW; i++) w[BW-1-i] = q[i];
    q.delete();
    tick(2 * PH);
    bus.en = 1'b0;
    tick(2 * PH);

    if (ok) begin
      checks++;
      if (n_valid - v0 !== 1) begin
        errors++;
        $display("FAIL %s valid pulses: got %0d, required 1", name, n_valid - v0);
      end
      checks++;
      if (cap !== w) begin
        errors++;
        $display("FAIL %s word: got %h, required %h", name, cap, w);
      end
      checks++;
      if (last_valid_cyc !== c_drive + 1 + SS) begin
        errors++;
        $display("FAIL %s latency: valid at cycle %0d, required %0d", name, last_valid_cyc, c_drive + 1 + SS);
      end
      checks++;
      if (n_err - e0 !== 0) begin
        errors++;
        $display("FAIL %s frame_err pulses: got %0d, required 0", name, n_err - e0);
      end
      exp_par = w;
    end else begin
      checks++;
      if (n_err - e0 !== 1) begin
        errors++;
        $display("FAIL %s frame_err pulses: got %0d, required 1", name, n_err - e0);
      end
      checks++;
      if (n_valid - v0 !== 0) begin
        errors++;
        $display("FAIL %s valid pulses: got %0d, required 0", name, n_valid - v0);
      end
    end
    checks++;
    if (bus.par_out !== exp_par) begin
      errors++;
      $display("FAIL %s par_out: got %h, required %h", name, bus.par_out, exp_par);
    end
    check_count({name, " after en"});
  endtask

  task automatic test_reset();
    bus.sclk  = 1'b1;
    bus.sclrn = 1'b1;
    bus.sout  = 1'b0;
    bus.en    = 1'b0;
    rst       = 1'b1;
    tick(3);
    checks++;
    if (bus.par_out !== '0 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.busy !== 1'b0 || bus.bit_count !== '0) begin
      errors++;
      $display("FAIL reset outputs: got par=%h v=%b e=%b busy=%b cnt=%0d, required all 0",
               bus.par_out, bus.valid, bus.frame_err, bus.busy, bus.bit_count);
    end
    rst = 1'b0;
    tick(2 * SS + 4);
    checks++;
    if (n_valid !== 0 || n_err !== 0) begin
      errors++;
      $display("FAIL reset spurious: got valid=%0d err=%0d pulses, required 0/0", n_valid, n_err);
    end
  endtask

  task automatic test_good();
    clear_pulse("good", 1);
    send_word(64'hDEAD_BEEF_0123_4567);
    check_count("good full");
    frame_end("good", 1'b0, 1'b0);
  endtask

  task automatic test_short();
    send_bit(1'b1);
    check_count("short bit1");
    for (int i = 1; i < BW - 1; i++) send_bit(1'($urandom));
    check_count("short bit63");
    frame_end("short", 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < BW + 2; i++) send_bit(i[0]);
    check_count("overrun");
    frame_end("overrun", 1'b0, 1'b0);
    send_word(64'h0000_0000_0000_0001);
    frame_end("after overrun", 1'b0, 1'b0);
  endtask

  task automatic test_sclrn();
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    check_count("sclrn pre");
    clear_pulse("sclrn", 4);
    send_word(64'hFFFF_0000_FFFF_0000);
    frame_end("sclrn frame", 1'b0, 1'b0);
  endtask

  task automatic test_coincident();
    bit last_b;
    for (int i = 0; i < BW - 1; i++) send_bit(1'($urandom));
    last_b = ~exp_par[0];
    frame_end("coincident", 1'b1, last_b);
    checks++;
    if (bus.par_out[0] !== last_b) begin
      errors++;
      $display("FAIL coincident bit0: got %b, required %b", bus.par_out[0], last_b);
    end
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 6; k++) begin
      len = (k % 2 == 0) ? BW : int'($urandom_range(BW + 2, BW - 2));
      for (int i = 0; i < len; i++) send_bit(1'($urandom));
      check_count("random len");
      frame_end("random", 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    for (int i = 0; i < 40; i++) send_bit(1'($urandom));
    v0  = n_valid;
    rst = 1'b1;
    tick(2);
    q.delete();
    exp_par = '0;
    checks++;
    if (bus.par_out !== '0 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.busy !== 1'b0 || bus.bit_count !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got par=%h v=%b e=%b busy=%b cnt=%0d, required all 0",
               bus.par_out, bus.valid, bus.frame_err, bus.busy, bus.bit_count);
    end
    rst = 1'b0;
    tick(PH);
    checks++;
    if (n_valid !== v0) begin
      errors++;
      $display("FAIL reset_mid spurious valid: got %0d pulses, required 0", n_valid - v0);
    end
    frame_end("zero-bit", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good();
    test_short();
    test_overrun();
    test_sclrn();
    test_coincident();
    test_random();
    test_reset_mid();
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL exclusive: valid and frame_err together in %0d cycles, required 0", n_both);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2p_receiver.md
Name: s2p_receiver

Overview:
- Receive-side counterpart of the seven-segment serial display link: deserialises the sclk/sclrn/sout/EN stream produced by the display serializer back into a BIT_WIDTH-bit parallel word.
- Used as the on-chip loopback checker and debug capture for the segment-data path.
- Inputs are treated as asynchronous to clk; they are synchronised and edge-detected before use.
- Delivers each complete frame with a one-cycle valid pulse; flags malformed frames.

Parameters:
- BIT_WIDTH, 64, frame length in bits; must be >= 2.
- SYNC_STAGES, 2, synchroniser depth on sclk/sclrn/sout/en; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  serial clock; data sampled on its rising edge.
- sclrn  input  1  active-low clear of the receive shift register.
- sout  input  1  serial data, MSB of frame first.
- en  input  1  frame latch strobe; rising edge ends the frame.
- par_out  output  BIT_WIDTH  last accepted frame.
- valid  output  1  one-cycle pulse when par_out updates.
- frame_err  output  1  one-cycle pulse on a bad frame.
- busy  output  1  high while a frame is partially received.
- bit_count  output  clog2(BIT_WIDTH+1)  bits received in the current frame.

Behaviour:
- Reset (rst=1 at clk edge):
  - Output and state values: par_out=0, valid=0, frame_err=0, busy=0, bit_count=0, shift register=0, overrun=0.
  - Synchroniser chains load idle levels: sclk=1, sclrn=1, sout=0, en=0, so no spurious edge follows reset.
  - Reset mid-frame discards the partial frame.
- Synchronisation:
  - sclk, sclrn, sout and en each pass through SYNC_STAGES flops; the same stage index is used for all four.
  - sout is therefore aligned with sclk.
  - Edge detect compares the last sync stage with a one-flop delayed copy.
- Priority per clk cycle, highest first: rst, sclrn_sync low, sclk rise, en rise.
- sclrn_sync low (level):
  - Clears the shift register, bit_count, overrun and busy.
  - Ignores sclk and en edges in that cycle.
  - par_out is unchanged.
- sclk rise:
  - Shift: shreg <= {shreg[BIT_WIDTH-2:0], sout_sync}.
  - If bit_count < BIT_WIDTH, bit_count increments.
  - Otherwise bit_count holds at BIT_WIDTH and overrun sets; extra bits still shift, so the oldest bits are lost.
  - busy=1 whenever bit_count != 0.
- en rise (evaluated after any same-cycle shift, i.e. using the post-shift count and data):
  - Good frame: updated bit_count == BIT_WIDTH and overrun=0.
    - par_out <= shreg (post-shift value) on this edge.
    - valid=1 for exactly this cycle.
  - Bad frame: any other case (short frame, zero bits, overrun).
    - frame_err=1 for one cycle; par_out and valid unchanged.
  - Either way: bit_count=0, overrun=0, busy=0 on the same edge. shreg keeps its contents but is irrelevant until the next full frame.
- en held high produces a single evaluation; a new frame needs en low then high.
- Latency: valid asserts SYNC_STAGES+1 clk cycles after the first clk edge at which raw en is sampled high.
- The input clock rate is bounded, not checked: sclk high and low phases must each last >= SYNC_STAGES+1 clk cycles. Faster input is out of spec, and the block must not hang; it simply misses edges.
- valid and frame_err are never high in the same cycle.
- No back-pressure: a consumer that misses valid loses the word; par_out holds until the next good frame.

Test Plan:
- Good frame: reset, sclrn pulse, 64 sclk edges shifting 64'hDEAD_BEEF_0123_4567 MSB first, en pulse → par_out=64'hDEAD_BEEF_0123_4567, valid single pulse exactly SYNC_STAGES+1 cycles after en sampled, frame_err=0, bit_count returns to 0.
- Short frame: 63 bits then en → frame_err one pulse; valid=0; par_out keeps previous value; busy=1 during bits 1–63, 0 after en.
- Overrun: 66 bits of alternating pattern, then en → frame_err pulse, par_out unchanged. Follow with a clean 64-bit frame 64'h0000_0000_0000_0001 → valid, correct value.
- Mid-frame sclrn: 30 bits, sclrn low for 4 sclk-periods, then full 64-bit frame 64'hFFFF_0000_FFFF_0000 + en → valid with exact value; bit_count was 0 during sclrn low.
- Coincident edges: drive the 64th sclk rise and the en rise in the same synchronised cycle → frame accepted (valid=1) with bit 0 equal to that last sout.
- Reset mid-frame: rst asserted after 40 bits, released, en pulse alone → frame_err pulse (zero-bit frame), all outputs at reset values beforehand, no spurious valid.
